// File: rtl/classifier_mac_argmax_stream.sv
// Output-layer MAC + running argmax over NUM_CLASSES x FEATS signed (x,w) pairs; optional CLS_SAT_EN saturates the accumulator.
// done pulses 2 cycles after the last accepted pair; in_ready is high only while accumulating, so input stalls freeze all state.
module classifier_mac_argmax_stream #(
   parameter int X_BITS      = 4,
   parameter int W_BITS      = 8,
   parameter int ACC_BITS    = 20,
   parameter int NUM_CLASSES = 10,
   parameter int FEATS       = 64,
   parameter int CLS_BITS    = $clog2(NUM_CLASSES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [X_BITS-1:0]   x_in,
   input  logic [W_BITS-1:0]   w_in,
   output logic                busy,
   output logic                done,
   output logic                result_valid,
   output logic [CLS_BITS-1:0] max_class,
   output logic [ACC_BITS-1:0] max_score,
   output logic [ACC_BITS-1:0] acc_out
);

   localparam int P_BITS = X_BITS + W_BITS;
   localparam int F_BITS = (FEATS > 1) ? $clog2(FEATS) : 1;
   localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
   localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CLOSE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ACC_BITS-1:0] acc_q, acc_d;
   logic [F_BITS-1:0]   feat_cnt_q, feat_cnt_d;
   logic [CLS_BITS-1:0] cls_cnt_q, cls_cnt_d;
   logic [ACC_BITS-1:0] max_score_q, max_score_d;
   logic [CLS_BITS-1:0] max_class_q, max_class_d;
   logic                done_q, done_d;
   logic                result_valid_q, result_valid_d;

   logic signed [P_BITS-1:0] prod;
   logic [ACC_BITS-1:0]      prod_ext;
   logic [ACC_BITS-1:0]      acc_sum;
`ifdef CLS_SAT_EN
   logic [ACC_BITS:0]        sum_wide;
`endif

   always_comb begin
      prod     = P_BITS'($signed(x_in)) * P_BITS'($signed(w_in));
      prod_ext = ACC_BITS'(prod);
`ifdef CLS_SAT_EN
      // One guard bit exposes overflow; clamp toward the sign of the true sum.
      sum_wide = {acc_q[ACC_BITS-1], acc_q} + {prod_ext[ACC_BITS-1], prod_ext};
      if (sum_wide[ACC_BITS] != sum_wide[ACC_BITS-1]) begin
         acc_sum = sum_wide[ACC_BITS] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_sum = sum_wide[ACC_BITS-1:0];
      end
`else
      acc_sum = acc_q + prod_ext;
`endif
   end

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      feat_cnt_d     = feat_cnt_q;
      cls_cnt_d      = cls_cnt_q;
      max_score_d    = max_score_q;
      max_class_d    = max_class_q;
      done_d         = 1'b0;
      result_valid_d = result_valid_q;
      in_ready       = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d        = S_ACCUM;
               acc_d          = '0;
               feat_cnt_d     = '0;
               cls_cnt_d      = '0;
               max_score_d    = ACC_MIN;
               max_class_d    = '0;
               result_valid_d = 1'b0;
            end
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = acc_sum;
               if (feat_cnt_q == F_BITS'(FEATS - 1)) begin
                  feat_cnt_d = '0;
                  state_d    = S_CLOSE;
               end else begin
                  feat_cnt_d = feat_cnt_q + 1'b1;
               end
            end
         end
         S_CLOSE: begin
            // Strict compare: on a tie the earlier (lower) class keeps the win.
            if ($signed(acc_q) > $signed(max_score_q)) begin
               max_score_d = acc_q;
               max_class_d = cls_cnt_q;
            end
            acc_d = '0;
            if (cls_cnt_q == CLS_BITS'(NUM_CLASSES - 1)) begin
               state_d        = S_DONE;
               done_d         = 1'b1;
               result_valid_d = 1'b1;
            end else begin
               cls_cnt_d = cls_cnt_q + 1'b1;
               state_d   = S_ACCUM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         acc_q          <= '0;
         feat_cnt_q     <= '0;
         cls_cnt_q      <= '0;
         max_score_q    <= '0;
         max_class_q    <= '0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         feat_cnt_q     <= feat_cnt_d;
         cls_cnt_q      <= cls_cnt_d;
         max_score_q    <= max_score_d;
         max_class_q    <= max_class_d;
         done_q         <= done_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign busy         = (state_q == S_ACCUM) || (state_q == S_CLOSE);
   assign done         = done_q;
   assign result_valid = result_valid_q;
   assign max_class    = max_class_q;
   assign max_score    = max_score_q;
   assign acc_out      = acc_q;

endmodule

// File: tb/tb_classifier_mac_argmax_stream.sv
// Bench: small engine (3 classes x 2 feats) for function/control, narrow engine (12-bit acc, 40 feats) for overflow.
module tb_classifier_mac_argmax_stream;

   localparam int NC_A = 3;
   localparam int FE_A = 2;
   localparam int AB_A = 20;
   localparam int NC_B = 2;
   localparam int FE_B = 40;
   localparam int AB_B = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_start = 0, a_in_valid = 0, a_in_ready, a_busy, a_done, a_result_valid;
   logic [3:0]  a_x_in = '0;
   logic [7:0]  a_w_in = '0;
   logic [1:0]  a_max_class;
   logic [19:0] a_max_score, a_acc_out;

   logic        b_start = 0, b_in_valid = 0, b_in_ready, b_busy, b_done, b_result_valid;
   logic [3:0]  b_x_in = '0;
   logic [7:0]  b_w_in = '0;
   logic        b_max_class;
   logic [11:0] b_max_score, b_acc_out;

   classifier_mac_argmax_stream #(.X_BITS(4), .W_BITS(8), .ACC_BITS(AB_A), .NUM_CLASSES(NC_A), .FEATS(FE_A)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .x_in(a_x_in), .w_in(a_w_in), .busy(a_busy), .done(a_done), .result_valid(a_result_valid),
      .max_class(a_max_class), .max_score(a_max_score), .acc_out(a_acc_out));

   classifier_mac_argmax_stream #(.X_BITS(4), .W_BITS(8), .ACC_BITS(AB_B), .NUM_CLASSES(NC_B), .FEATS(FE_B)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .x_in(b_x_in), .w_in(b_w_in), .busy(b_busy), .done(b_done), .result_valid(b_result_valid),
      .max_class(b_max_class), .max_score(b_max_score), .acc_out(b_acc_out));

   int     tests = 0;
   int     fails = 0;
   int     sx[$];
   int     sw[$];
   longint exp_score[16];
   int     exp_cls;
   longint exp_max;
   int     last_dec_cyc;

   // Reference: per-class sum of products, wrapped or clamped after every add, then strict argmax.
   function automatic longint fix_range(input longint v, input int bits);
      longint m, r;
      m = longint'(1) << bits;
`ifdef CLS_SAT_EN
      if (v > m / 2 - 1) r = m / 2 - 1;
      else if (v < -(m / 2)) r = -(m / 2);
      else r = v;
`else
      r = v % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
`endif
      return r;
   endfunction

   task automatic compute_expected(input int nc, input int feats, input int bits);
      longint s;
      exp_max = -(longint'(1) << (bits - 1));
      exp_cls = 0;
      for (int c = 0; c < nc; c++) begin
         s = 0;
         for (int f = 0; f < feats; f++) s = fix_range(s + sx[c*feats+f] * sw[c*feats+f], bits);
         exp_score[c] = s;
         if (s > exp_max) begin
            exp_max = s;
            exp_cls = c;
         end
      end
   endtask

   task automatic load(input int xs[], input int ws[]);
      sx.delete(); sw.delete();
      foreach (xs[i]) begin sx.push_back(xs[i]); sw.push_back(ws[i]); end
      compute_expected(NC_A, FE_A, AB_A);
   endtask

   task automatic start_a();
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
   endtask

   // Feeds pairs lo..hi-1 into engine A; checks acc_out in the CLOSE cycle of each finished class.
   task automatic drive_stream(input int lo, input int hi, input bit gaps);
      int i = lo, budget = 0, c = 0;
      bit chk = 0;
      logic [19:0] e;
      while (i < hi && budget < 5000) begin
         @(negedge clk); budget++;
         if (chk) begin
            tests++; e = 20'(exp_score[c]);
            if (a_acc_out !== e) begin fails++; $display("FAIL acc_out class %0d: got %0d want %0d", c, $signed(a_acc_out), $signed(e)); end
            chk = 0;
         end
         a_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         a_x_in = 4'(sx[i]);
         a_w_in = 8'(sw[i]);
         if (a_in_valid && a_in_ready) begin
            last_dec_cyc = cyc;
            if ((i + 1) % FE_A == 0) begin chk = 1; c = i / FE_A; end
            i++;
         end
      end
      if (i < hi) begin tests++; fails++; $display("FAIL stream timeout: accepted %0d want %0d", i, hi); end
      @(negedge clk); a_in_valid = 1'b0;
      if (chk) begin
         tests++; e = 20'(exp_score[c]);
         if (a_acc_out !== e) begin fails++; $display("FAIL acc_out class %0d: got %0d want %0d", c, $signed(a_acc_out), $signed(e)); end
      end
   endtask

   task automatic wait_done_check(input string name);
      int n = 0;
      logic [19:0] e;
      while (a_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests++;
      if (a_done !== 1'b1) begin fails++; $display("FAIL %s done timeout: got %b want 1", name, a_done); end
      tests++;
      if (cyc - last_dec_cyc != 2) begin fails++; $display("FAIL %s latency: got %0d want 2", name, cyc - last_dec_cyc); end
      tests++; e = 20'(exp_max);
      if (a_max_score !== e) begin fails++; $display("FAIL %s max_score: got %0d want %0d", name, $signed(a_max_score), $signed(e)); end
      tests++;
      if (a_max_class !== 2'(exp_cls)) begin fails++; $display("FAIL %s max_class: got %0d want %0d", name, a_max_class, exp_cls); end
      tests++;
      if (a_result_valid !== 1'b1 || a_busy !== 1'b0) begin fails++; $display("FAIL %s flags: got rv=%b busy=%b want rv=1 busy=0", name, a_result_valid, a_busy); end
      @(negedge clk);
      tests++;
      if (a_done !== 1'b0 || a_result_valid !== 1'b1 || a_in_ready !== 1'b0) begin
         fails++; $display("FAIL %s hold: got done=%b rv=%b rdy=%b want 0 1 0", name, a_done, a_result_valid, a_in_ready);
      end
   endtask

   task automatic check_reset_vals(input string name);
      tests++;
      if ({a_in_ready, a_busy, a_done, a_result_valid} !== 4'b0 || a_max_class !== 2'd0 || a_max_score !== 20'd0 || a_acc_out !== 20'd0) begin
         fails++; $display("FAIL %s A: got rdy=%b busy=%b done=%b rv=%b cls=%0d score=%0d acc=%0d want all 0", name,
                           a_in_ready, a_busy, a_done, a_result_valid, a_max_class, a_max_score, a_acc_out);
      end
      tests++;
      if ({b_in_ready, b_busy, b_done, b_result_valid, b_max_class} !== 5'b0 || b_max_score !== 12'd0 || b_acc_out !== 12'd0) begin
         fails++; $display("FAIL %s B: got rdy=%b busy=%b done=%b rv=%b score=%0d acc=%0d want all 0", name,
                           b_in_ready, b_busy, b_done, b_result_valid, b_max_score, b_acc_out);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("idle");
   endtask

   task automatic test_t1();
      load('{1, 2, -1, 0, 3, 1}, '{5, 3, 4, 7, 3, 1});
      start_a();
      tests++;
      if (a_busy !== 1'b1 || a_in_ready !== 1'b1 || a_max_score !== 20'h80000) begin
         fails++; $display("FAIL start state: got busy=%b rdy=%b score=%h want 1 1 80000", a_busy, a_in_ready, a_max_score);
      end
      drive_stream(0, 6, 1'b0);
      wait_done_check("t1");
   endtask

   task automatic test_t2_negative();
      load('{-1, 0, -1, 0, -5, 0}, '{8, 0, 3, 5, 1, 1});
      start_a();
      drive_stream(0, 6, 1'b0);
      wait_done_check("t2");
   endtask

   task automatic test_t3_tie_gaps();
      load('{2, 0, 3, 0, 1, 0}, '{3, 1, 2, 0, 2, 9});
      start_a();
      drive_stream(0, 6, 1'b1);
      wait_done_check("t3");
   endtask

   task automatic test_t4_rst_mid();
      load('{7, -8, 5, 6, 1, 1}, '{127, -128, 100, 50, 1, 1});
      start_a();
      drive_stream(0, 3, 1'b0);
      @(negedge clk); rst = 1'b1; a_start = 1'b1;
      @(negedge clk); rst = 1'b0; a_start = 1'b0;
      check_reset_vals("rst_mid");
      load('{1, 2, -1, 0, 3, 1}, '{5, 3, 4, 7, 3, 1});
      start_a();
      drive_stream(0, 6, 1'b0);
      wait_done_check("t4");
   endtask

   task automatic test_t6_start();
      load('{1, 2, -1, 0, 3, 1}, '{5, 3, 4, 7, 3, 1});
      start_a();
      drive_stream(0, 1, 1'b0);
      start_a();
      tests++;
      if (a_busy !== 1'b1 || a_acc_out !== 20'd5) begin
         fails++; $display("FAIL busy start: got busy=%b acc=%0d want 1 5", a_busy, $signed(a_acc_out));
      end
      drive_stream(1, 6, 1'b0);
      wait_done_check("t6a");
      load('{-1, 0, -1, 0, -5, 0}, '{8, 0, 3, 5, 1, 1});
      start_a();
      tests++;
      if (a_result_valid !== 1'b0 || a_busy !== 1'b1 || a_done !== 1'b0) begin
         fails++; $display("FAIL restart: got rv=%b busy=%b done=%b want 0 1 0", a_result_valid, a_busy, a_done);
      end
      drive_stream(0, 6, 1'b1);
      wait_done_check("t6b");
   endtask

   task automatic test_random();
      int xs[6], ws[6];
      for (int k = 0; k < 15; k++) begin
         for (int j = 0; j < 6; j++) begin
            xs[j] = $urandom_range(0, 15) - 8;
            ws[j] = $urandom_range(0, 255) - 128;
         end
         if (k % 5 == 0) begin ws[2] = ws[0]; xs[2] = xs[0]; ws[3] = ws[1]; xs[3] = xs[1]; end
         load(xs, ws);
         start_a();
         drive_stream(0, 6, k[0]);
         wait_done_check("rand");
      end
   endtask

   task automatic test_t5_overflow();
      int i = 0, budget = 0;
      logic [11:0] e;
      sx.delete(); sw.delete();
      for (int j = 0; j < FE_B; j++) begin sx.push_back(7); sw.push_back(127); end
      for (int j = 0; j < FE_B; j++) begin sx.push_back($urandom_range(0, 15) - 8); sw.push_back($urandom_range(0, 255) - 128); end
      compute_expected(NC_B, FE_B, AB_B);
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      while (i < 2 * FE_B && budget < 1000) begin
         b_in_valid = 1'b1; b_x_in = 4'(sx[i]); b_w_in = 8'(sw[i]);
         if (b_in_ready) i++;
         @(negedge clk); budget++;
         if (i == FE_B && b_in_ready === 1'b0 && b_busy === 1'b1) begin
            tests++; e = 12'(exp_score[0]);
            if (b_acc_out !== e) begin fails++; $display("FAIL ovf class0: got %0d want %0d", $signed(b_acc_out), $signed(e)); end
         end
      end
      b_in_valid = 1'b0;
      budget = 0;
      while (b_result_valid !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
      tests++; e = 12'(exp_max);
      if (b_result_valid !== 1'b1 || b_max_score !== e || b_max_class !== 1'(exp_cls)) begin
         fails++; $display("FAIL ovf result: got rv=%b cls=%0d score=%0d want 1 %0d %0d", b_result_valid, b_max_class,
                           $signed(b_max_score), exp_cls, $signed(e));
      end
   endtask

   initial begin
      test_reset();
      test_t1();
      test_t2_negative();
      test_t3_tie_gaps();
      test_t4_rst_mid();
      test_t6_start();
      test_random();
      test_t5_overflow();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
